// File: rtl/mac_sequencer.sv
// Multi-cycle 8x8 unsigned multiply-accumulate sequencer. One shared 20-bit
// carry-select adder does both the shift-add product and the accumulation.

module carry_select20 (
  input  logic [19:0] a,
  input  logic [19:0] b,
  input  logic        carry_in,
  output logic [19:0] sum,
  output logic        carry_out
);

  localparam int BLK_W  = 4;
  localparam int N_BLKS = 20 / BLK_W;

  logic [19:0]       sum_c0;
  logic [19:0]       sum_c1;
  logic [N_BLKS-1:0] co_c0;
  logic [N_BLKS-1:0] co_c1;

  // Each nibble precomputes both carry-in cases; the chain below only selects.
  genvar g;
  generate
    for (g = 0; g < N_BLKS; g++) begin : g_blk
      assign {co_c0[g], sum_c0[g*BLK_W +: BLK_W]} =
        {1'b0, a[g*BLK_W +: BLK_W]} + {1'b0, b[g*BLK_W +: BLK_W]};
      assign {co_c1[g], sum_c1[g*BLK_W +: BLK_W]} =
        {1'b0, a[g*BLK_W +: BLK_W]} + {1'b0, b[g*BLK_W +: BLK_W]} + 5'd1;
    end
  endgenerate

  always_comb begin
    logic carry;
    sum   = '0;
    carry = carry_in;
    for (int i = 0; i < N_BLKS; i++) begin
      sum[i*BLK_W +: BLK_W] = carry ? sum_c1[i*BLK_W +: BLK_W] : sum_c0[i*BLK_W +: BLK_W];
      carry                 = carry ? co_c1[i] : co_c0[i];
    end
    carry_out = carry;
  end

endmodule

module mac_sequencer #(
  parameter int OP_W     = 8,
  parameter int ACC_W    = 20,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  output logic             overflow
);

  localparam int CNT_W = $clog2(OP_W);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  generate
    if (OP_W != 8 || ACC_W != 20) begin : g_bad_params
      $error("mac_sequencer supports only OP_W=8 and ACC_W=20");
    end
  endgenerate

  logic [1:0]       state;
  logic [OP_W-1:0]  a_reg;
  logic [OP_W-1:0]  b_reg;
  logic             clear_reg;
  logic [ACC_W-1:0] partial;
  logic [CNT_W-1:0] count;

  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] add_b;
  logic [ACC_W-1:0] add_sum;
  logic             add_co;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // The single adder is time-shared: shift-add terms in MUL, accumulate in ACC.
  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state)
      ST_MUL: begin
        add_a = partial;
        add_b = b_reg[count] ? (ACC_W'(a_reg) << count) : '0;
      end
      ST_ACC: begin
        add_a = clear_reg ? '0 : acc_out;
        add_b = partial;
      end
      default: ;
    endcase
  end

  carry_select20 u_adder (
    .a         (add_a),
    .b         (add_b),
    .carry_in  (1'b0),
    .sum       (add_sum),
    .carry_out (add_co)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      clear_reg <= 1'b0;
      partial   <= '0;
      count     <= '0;
      acc_out   <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            clear_reg <= clear;
            partial   <= '0;
            count     <= '0;
            state     <= ST_MUL;
          end
        end
        ST_MUL: begin
          partial <= add_sum;
          count   <= count + 1'b1;
          if (count == CNT_W'(OP_W - 1)) begin
            state <= ST_ACC;
          end
        end
        ST_ACC: begin
          // A clearing MAC restarts the sticky flag from this carry alone.
          if (add_co) begin
            overflow <= 1'b1;
            acc_out  <= SATURATE ? '1 : add_sum;
          end else begin
            overflow <= clear_reg ? 1'b0 : overflow;
            acc_out  <= add_sum;
          end
          state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: a wrapping and a saturating instance run
// in lockstep, each checked against a behavioural accumulate model.

module tb_mac_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n;
  logic       in_valid;
  logic       clear;
  logic [7:0] a;
  logic [7:0] b;

  logic        in_ready_w, out_valid_w, overflow_w;
  logic [19:0] acc_w;
  logic        in_ready_s, out_valid_s, overflow_s;
  logic [19:0] acc_s;

  mac_sequencer #(.OP_W(8), .ACC_W(20), .SATURATE(1'b0)) dut_wrap (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a), .b(b), .clear(clear), .acc_out(acc_w), .out_valid(out_valid_w),
    .overflow(overflow_w)
  );

  mac_sequencer #(.OP_W(8), .ACC_W(20), .SATURATE(1'b1)) dut_sat (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .clear(clear), .acc_out(acc_s), .out_valid(out_valid_s),
    .overflow(overflow_s)
  );

  typedef struct packed {
    logic [19:0] acc_w;
    logic        ovf_w;
    logic [19:0] acc_s;
    logic        ovf_s;
  } exp_t;

  exp_t        sb[$];
  logic [19:0] m_acc_w, m_acc_s;
  logic        m_ovf_w, m_ovf_s;
  int          compared   = 0;
  int          mismatched = 0;

  task automatic model_reset();
    m_acc_w = '0; m_acc_s = '0; m_ovf_w = 1'b0; m_ovf_s = 1'b0;
    sb.delete();
  endtask

  task automatic model_push(input logic [7:0] ma, input logic [7:0] mb, input logic mclr);
    logic [20:0] prod, s;
    exp_t e;
    prod    = 21'(ma) * 21'(mb);
    s       = (mclr ? 21'd0 : {1'b0, m_acc_w}) + prod;
    m_ovf_w = (mclr ? 1'b0 : m_ovf_w) | s[20];
    m_acc_w = s[19:0];
    s       = (mclr ? 21'd0 : {1'b0, m_acc_s}) + prod;
    m_ovf_s = (mclr ? 1'b0 : m_ovf_s) | s[20];
    m_acc_s = s[20] ? 20'hFFFFF : s[19:0];
    e.acc_w = m_acc_w; e.ovf_w = m_ovf_w; e.acc_s = m_acc_s; e.ovf_s = m_ovf_s;
    sb.push_back(e);
  endtask

  // Presents one operand for exactly one accept edge, then scrambles the inputs.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic iclr);
    int guard;
    guard = 0;
    @(negedge clock);
    while (!in_ready_w && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    if (!in_ready_w) begin
      compared++; mismatched++;
      $display("[TB] FAIL issue_ready: in_ready=%b required 1 within 40 cycles", in_ready_w);
    end
    in_valid = 1'b1; a = ia; b = ib; clear = iclr;
    model_push(ia, ib, iclr);
    @(posedge clock);
    #1;
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); clear = 1'($urandom);
  endtask

  task automatic wait_out(output int lat, output bit seen, output int low_cnt);
    lat = 0; seen = 1'b0; low_cnt = 0;
    while (!seen && lat < 40) begin
      @(negedge clock);
      lat++;
      if (!in_ready_w) low_cnt++;
      if (out_valid_w) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; clear = 1'b0; a = '0; b = '0;
    model_reset();
    #12;
    compared++;
    if ({in_ready_w, out_valid_w, acc_w, overflow_w} !== {1'b1, 1'b0, 20'd0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL reset_wrap: rdy=%b ov=%b acc=%0d ovf=%b required 1 0 0 0",
               in_ready_w, out_valid_w, acc_w, overflow_w);
    end
    compared++;
    if ({in_ready_s, out_valid_s, acc_s, overflow_s} !== {1'b1, 1'b0, 20'd0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL reset_sat: rdy=%b ov=%b acc=%0d ovf=%b required 1 0 0 0",
               in_ready_s, out_valid_s, acc_s, overflow_s);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, low_cnt;
    bit seen;
    exp_t e;
    issue(8'd3, 8'd5, 1'b1);
    wait_out(lat, seen, low_cnt);
    if (!seen) begin
      compared++; mismatched++;
      $display("[TB] FAIL basic_timeout: no out_valid after %0d cycles, required 10", lat);
    end else begin
      e = sb.pop_front();
      compared++;
      if (lat != 10) begin mismatched++; $display("[TB] FAIL basic_latency: got %0d required 10", lat); end
      compared++;
      if (low_cnt != 10) begin mismatched++; $display("[TB] FAIL basic_ready_low: got %0d required 10", low_cnt); end
      compared++;
      if (acc_w !== e.acc_w) begin mismatched++; $display("[TB] FAIL basic_acc: got %0d required %0d", acc_w, e.acc_w); end
      compared++;
      if (overflow_w !== e.ovf_w) begin mismatched++; $display("[TB] FAIL basic_ovf: got %b required %b", overflow_w, e.ovf_w); end
      compared++;
      if (out_valid_s !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_sat_valid: got %b required 1", out_valid_s); end
      @(negedge clock);
      compared++;
      if ({out_valid_w, in_ready_w} !== 2'b01) begin
        mismatched++;
        $display("[TB] FAIL basic_pulse_end: valid=%b ready=%b required 0 1", out_valid_w, in_ready_w);
      end
    end
  endtask

  task automatic test_accumulate();
    int lat, low_cnt;
    bit seen;
    exp_t e;
    for (int n = 0; n < 17; n++) begin
      issue(8'd255, 8'd255, (n == 0));
      wait_out(lat, seen, low_cnt);
      if (!seen) begin
        compared++; mismatched++;
        $display("[TB] FAIL accum_timeout: mac %0d no out_valid, required within 40", n);
      end else begin
        e = sb.pop_front();
        compared++;
        if (acc_w !== e.acc_w) begin mismatched++; $display("[TB] FAIL accum_acc_wrap: mac %0d got %0d required %0d", n, acc_w, e.acc_w); end
        compared++;
        if (overflow_w !== e.ovf_w) begin mismatched++; $display("[TB] FAIL accum_ovf_wrap: mac %0d got %b required %b", n, overflow_w, e.ovf_w); end
        compared++;
        if (acc_s !== e.acc_s) begin mismatched++; $display("[TB] FAIL accum_acc_sat: mac %0d got %0d required %0d", n, acc_s, e.acc_s); end
        compared++;
        if (overflow_s !== e.ovf_s) begin mismatched++; $display("[TB] FAIL accum_ovf_sat: mac %0d got %b required %b", n, overflow_s, e.ovf_s); end
      end
    end
  endtask

  task automatic test_clear_after_overflow();
    int lat, low_cnt;
    bit seen;
    exp_t e;
    issue(8'd0, 8'd9, 1'b1);
    wait_out(lat, seen, low_cnt);
    if (!seen) begin
      compared++; mismatched++;
      $display("[TB] FAIL clear_timeout: no out_valid after %0d cycles", lat);
    end else begin
      e = sb.pop_front();
      compared++;
      if ({acc_w, overflow_w} !== {e.acc_w, e.ovf_w}) begin
        mismatched++;
        $display("[TB] FAIL clear_wrap: acc=%0d ovf=%b required %0d %b", acc_w, overflow_w, e.acc_w, e.ovf_w);
      end
      compared++;
      if ({acc_s, overflow_s} !== {e.acc_s, e.ovf_s}) begin
        mismatched++;
        $display("[TB] FAIL clear_sat: acc=%0d ovf=%b required %0d %b", acc_s, overflow_s, e.acc_s, e.ovf_s);
      end
    end
  endtask

  task automatic test_zero_operand();
    int lat, low_cnt;
    bit seen;
    exp_t e;
    issue(8'd3, 8'd5, 1'b1);
    wait_out(lat, seen, low_cnt);
    if (seen) void'(sb.pop_front());
    issue(8'd200, 8'd0, 1'b0);
    wait_out(lat, seen, low_cnt);
    if (!seen) begin
      compared++; mismatched++;
      $display("[TB] FAIL zero_timeout: no out_valid after %0d cycles", lat);
    end else begin
      e = sb.pop_front();
      compared++;
      if (lat != 10) begin mismatched++; $display("[TB] FAIL zero_latency: got %0d required 10", lat); end
      compared++;
      if (acc_w !== e.acc_w) begin mismatched++; $display("[TB] FAIL zero_acc: got %0d required %0d", acc_w, e.acc_w); end
      compared++;
      if (overflow_w !== e.ovf_w) begin mismatched++; $display("[TB] FAIL zero_ovf: got %b required %b", overflow_w, e.ovf_w); end
    end
  endtask

  task automatic test_busy_ignore();
    int ov_at, rdy_at, lat, low_cnt;
    bit seen;
    logic [7:0] na, nb;
    exp_t e;
    @(negedge clock);
    in_valid = 1'b1; a = 8'd4; b = 8'd6; clear = 1'b1;
    model_push(8'd4, 8'd6, 1'b1);
    ov_at = -1; rdy_at = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clock);
      if (out_valid_w) begin
        ov_at = cyc;
        e = sb.pop_front();
        compared++;
        if ({acc_w, overflow_w} !== {e.acc_w, e.ovf_w}) begin
          mismatched++;
          $display("[TB] FAIL busy_first: acc=%0d ovf=%b required %0d %b", acc_w, overflow_w, e.acc_w, e.ovf_w);
        end
      end
      if (in_ready_w) begin
        rdy_at = cyc;
        na = 8'($urandom); nb = 8'($urandom);
        a = na; b = nb; clear = 1'b0;
        model_push(na, nb, 1'b0);
        break;
      end
      a = 8'($urandom); b = 8'($urandom); clear = 1'($urandom);
    end
    compared++;
    if (ov_at != 10 || rdy_at != 11) begin
      mismatched++;
      $display("[TB] FAIL busy_timing: out_valid at %0d ready at %0d required 10 11", ov_at, rdy_at);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    wait_out(lat, seen, low_cnt);
    if (!seen) begin
      compared++; mismatched++;
      $display("[TB] FAIL busy_second_timeout: no out_valid after %0d cycles", lat);
    end else begin
      e = sb.pop_front();
      compared++;
      if (acc_w !== e.acc_w) begin mismatched++; $display("[TB] FAIL busy_second_acc: got %0d required %0d", acc_w, e.acc_w); end
      compared++;
      if (acc_s !== e.acc_s) begin mismatched++; $display("[TB] FAIL busy_second_acc_sat: got %0d required %0d", acc_s, e.acc_s); end
    end
  endtask

  task automatic test_reset_mid_op();
    int stray, lat, low_cnt;
    bit seen;
    exp_t e;
    issue(8'd9, 8'd7, 1'b0);
    repeat (4) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    compared++;
    if ({in_ready_w, out_valid_w, acc_w, overflow_w} !== {1'b1, 1'b0, 20'd0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL midreset_outputs: rdy=%b ov=%b acc=%0d ovf=%b required 1 0 0 0",
               in_ready_w, out_valid_w, acc_w, overflow_w);
    end
    @(negedge clock);
    reset_n = 1'b1;
    stray = 0;
    repeat (15) begin
      @(negedge clock);
      if (out_valid_w || out_valid_s) stray++;
    end
    compared++;
    if (stray != 0) begin mismatched++; $display("[TB] FAIL midreset_no_valid: got %0d pulses required 0", stray); end
    issue(8'd2, 8'd2, 1'b0);
    wait_out(lat, seen, low_cnt);
    if (!seen) begin
      compared++; mismatched++;
      $display("[TB] FAIL midreset_timeout: no out_valid after %0d cycles", lat);
    end else begin
      e = sb.pop_front();
      compared++;
      if (acc_w !== e.acc_w) begin mismatched++; $display("[TB] FAIL midreset_acc: got %0d required %0d", acc_w, e.acc_w); end
      compared++;
      if (overflow_s !== e.ovf_s) begin mismatched++; $display("[TB] FAIL midreset_ovf_sat: got %b required %b", overflow_s, e.ovf_s); end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_accumulate();
    test_clear_after_overflow();
    test_zero_operand();
    test_busy_ignore();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
